// File: rtl/mcu_bus_pkg.sv
// Shared encodings for the MCU DRAM address-bus arbiter: slot owner codes and
// the DMA grant FSM state constants.
package mcu_bus_pkg;

  localparam int unsigned SRC_W = 3;

  typedef enum logic [SRC_W-1:0] {
    SrcIdle = 3'd0,
    SrcVid  = 3'd1,
    SrcSnd  = 3'd2,
    SrcRef  = 3'd3,
    SrcCpu  = 3'd4,
    SrcDma  = 3'd5
  } src_e;

  // Grant FSM states.
  localparam logic [1:0] CpuOwn     = 2'd0;
  localparam logic [1:0] DmaOwn     = 2'd1;
  localparam logic [1:0] DmaRelease = 2'd2;

  // Owners whose slot returns a data word that must be latched.
  function automatic logic is_data_src(src_e s);
    return (s == SrcVid) || (s == SrcSnd);
  endfunction

endpackage

// File: rtl/ram_slot_arbiter_if.sv
// Request/ack bundle between the slot arbiter (slave) and its requesters (master).
interface ram_slot_arbiter_if;
  import mcu_bus_pkg::*;

  logic             viden;
  logic             vid_req;
  logic             snd_en;
  logic             snd_req;
  logic             cpu_as;
  logic             dma_req;
  logic             dma_grant;
  logic [SRC_W-1:0] src;
  logic             slot_start;
  logic             odd_slot;
  logic             data_latch;
  logic             vid_ack;
  logic             snd_ack;
  logic             ref_ack;
  logic             ref_late;

  modport slave (
    input  viden, vid_req, snd_en, snd_req, cpu_as, dma_req,
    output dma_grant, src, slot_start, odd_slot, data_latch,
    output vid_ack, snd_ack, ref_ack, ref_late
  );

  modport master (
    output viden, vid_req, snd_en, snd_req, cpu_as, dma_req,
    input  dma_grant, src, slot_start, odd_slot, data_latch,
    input  vid_ack, snd_ack, ref_ack, ref_late
  );

endinterface

// File: rtl/refresh_timer.sv
// Refresh request generator: counts even slots, raises pending on wrap, tracks how
// many even slots a pending refresh has been passed over and flags overruns.
module refresh_timer #(
  parameter int unsigned RefInt  = 64,
  parameter int unsigned RefSlip = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic ref_granted_i,
  output logic pending_o,
  output logic slip_ok_o,
  output logic ref_late_o
);

  localparam int unsigned TmrW  = (RefInt > 1) ? $clog2(RefInt) : 1;
  localparam int unsigned SlipW = 8;

  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [SlipW-1:0] slip_q, slip_d;
  logic             pending_q, pending_d;
  logic             late_q, late_d;
  logic             wrap;

  always_comb begin
    wrap      = tick_i && (tmr_q == TmrW'(RefInt - 1));
    tmr_d     = tmr_q;
    slip_d    = slip_q;
    pending_d = pending_q;
    late_d    = late_q;
    if (tick_i) begin
      tmr_d = wrap ? '0 : tmr_q + 1'b1;
      if (ref_granted_i) begin
        pending_d = 1'b0;
        slip_d    = '0;
      end else if (pending_q && (slip_q != {SlipW{1'b1}})) begin
        slip_d = slip_q + 1'b1;
      end
      // A new period starting while the last refresh is still owed is an overrun.
      if (wrap) begin
        pending_d = 1'b1;
        if (pending_q && !ref_granted_i) begin
          late_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmr_q     <= '0;
      slip_q    <= '0;
      pending_q <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      slip_q    <= slip_d;
      pending_q <= pending_d;
      late_q    <= late_d;
    end
  end

  assign pending_o  = pending_q;
  assign slip_ok_o  = (slip_q >= SlipW'(RefSlip));
  assign ref_late_o = late_q;

endmodule

// File: rtl/ram_slot_arbiter.sv
// DRAM address-bus slot scheduler: even slots serve video/sound/refresh, odd slots
// serve CPU or disk DMA. Owners are decided on the last phase of each slot.
module ram_slot_arbiter
  import mcu_bus_pkg::*;
#(
  parameter int unsigned SLOT_LEN = 8,
  parameter int unsigned LATCH_PH = 5,
  parameter int unsigned REF_INT  = 64,
  parameter int unsigned REF_SLIP = 2
) (
  input logic               clk32,
  input logic               resb,
  ram_slot_arbiter_if.slave bus
);

  localparam int unsigned PhW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [PhW-1:0] LastPh  = PhW'(SLOT_LEN - 1);
  localparam logic [PhW-1:0] LatchPh = PhW'(LATCH_PH);

  logic [PhW-1:0] phase_q, phase_d;
  logic           odd_q, odd_d;
  src_e           src_q, src_d;
  src_e           even_src;
  logic [1:0]     gnt_q, gnt_d;
  logic           grant_next;
  logic           boundary;
  logic           tick;
  logic           ref_pending;
  logic           ref_slip_ok;
  logic           ref_late;

  assign boundary = (phase_q == LastPh);
  // Decision made at the end of an odd slot chooses the following even slot.
  assign tick     = boundary && odd_q;

  always_comb begin
    even_src = SrcIdle;
    if (ref_pending && ref_slip_ok) begin
      even_src = SrcRef;
    end else if (bus.viden && bus.vid_req) begin
      even_src = SrcVid;
    end else if (bus.snd_en && bus.snd_req) begin
      even_src = SrcSnd;
    end else if (ref_pending) begin
      even_src = SrcRef;
    end
  end

  // Grant rises only into an odd slot; a release seen on any cycle drops the
  // grant at the next boundary of either parity.
  always_comb begin
    gnt_d = gnt_q;
    case (gnt_q)
      CpuOwn: begin
        if (boundary && !odd_q && bus.dma_req && !bus.cpu_as) begin
          gnt_d = DmaOwn;
        end
      end
      DmaOwn: begin
        if (!bus.dma_req) begin
          gnt_d = DmaRelease;
        end
      end
      DmaRelease: begin
        if (boundary) begin
          gnt_d = CpuOwn;
        end
      end
      default: gnt_d = CpuOwn;
    endcase
  end

  assign grant_next = (gnt_d != CpuOwn);

  always_comb begin
    phase_d = phase_q + 1'b1;
    odd_d   = odd_q;
    src_d   = src_q;
    if (boundary) begin
      phase_d = '0;
      odd_d   = !odd_q;
      if (odd_q) begin
        src_d = even_src;
      end else begin
        src_d = grant_next ? SrcDma : SrcCpu;
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (!resb) begin
      phase_q <= '0;
      odd_q   <= 1'b0;
      src_q   <= SrcIdle;
      gnt_q   <= CpuOwn;
    end else begin
      phase_q <= phase_d;
      odd_q   <= odd_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
    end
  end

  refresh_timer #(
    .RefInt  (REF_INT),
    .RefSlip (REF_SLIP)
  ) u_refresh_timer (
    .clk_i         (clk32),
    .rst_ni        (resb),
    .tick_i        (tick),
    .ref_granted_i (tick && (even_src == SrcRef)),
    .pending_o     (ref_pending),
    .slip_ok_o     (ref_slip_ok),
    .ref_late_o    (ref_late)
  );

  assign bus.src        = src_q;
  assign bus.odd_slot   = odd_q;
  assign bus.slot_start = resb && (phase_q == '0);
  assign bus.data_latch = (phase_q == LatchPh) && is_data_src(src_q);
  assign bus.vid_ack    = boundary && (src_q == SrcVid);
  assign bus.snd_ack    = boundary && (src_q == SrcSnd);
  assign bus.ref_ack    = boundary && (src_q == SrcRef);
  assign bus.dma_grant  = (gnt_q != CpuOwn);
  assign bus.ref_late   = ref_late;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Bench for ram_slot_arbiter: two instances (refresh slip 2 and 255) share one
// stimulus stream and are compared every cycle against a slot-level model.
module tb_ram_slot_arbiter;

  localparam int SL = 8;
  localparam int LP = 5;
  localparam int RI = 4;
  localparam int IDLE = 0, VID = 1, SND = 2, REF = 3, CPU = 4, DMA = 5;

  logic clk32 = 1'b0;
  logic resb = 1'b0;
  logic viden = 1'b0, vid_req = 1'b0, snd_en = 1'b0, snd_req = 1'b0;
  logic cpu_as = 1'b0, dma_req = 1'b0;

  int tests = 0;
  int fails = 0;

  // Model state
  int pos = 0;
  int owner[2] = '{IDLE, IDLE};
  int tmr[2] = '{0, 0};
  int slip[2] = '{0, 0};
  bit pend[2] = '{1'b0, 1'b0};
  bit late[2] = '{1'b0, 1'b0};
  int slip_lim[2] = '{2, 255};
  bit granted = 1'b0;
  bit rel = 1'b0;

  ram_slot_arbiter_if bus_a ();
  ram_slot_arbiter_if bus_b ();

  assign bus_a.viden = viden;
  assign bus_a.vid_req = vid_req;
  assign bus_a.snd_en = snd_en;
  assign bus_a.snd_req = snd_req;
  assign bus_a.cpu_as = cpu_as;
  assign bus_a.dma_req = dma_req;
  assign bus_b.viden = viden;
  assign bus_b.vid_req = vid_req;
  assign bus_b.snd_en = snd_en;
  assign bus_b.snd_req = snd_req;
  assign bus_b.cpu_as = cpu_as;
  assign bus_b.dma_req = dma_req;

  ram_slot_arbiter #(.SLOT_LEN(SL), .LATCH_PH(LP), .REF_INT(RI), .REF_SLIP(2)) dut_a (
    .clk32 (clk32),
    .resb  (resb),
    .bus   (bus_a)
  );

  ram_slot_arbiter #(.SLOT_LEN(SL), .LATCH_PH(LP), .REF_INT(RI), .REF_SLIP(255)) dut_b (
    .clk32 (clk32),
    .resb  (resb),
    .bus   (bus_b)
  );

  always #5 clk32 = ~clk32;

  task automatic check(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cfg%0d pos=%0d observed=%0h expected=%0h", tag, c, pos, obs, exp);
    end
  endtask

  task automatic check_cfg(input int c, input logic [2:0] src, input logic odd,
                           input logic ss, input logic dl, input logic va, input logic sa,
                           input logic ra, input logic dg, input logic rl);
    int  ph;
    bit  data_src;
    ph = pos % SL;
    data_src = (owner[c] == VID) || (owner[c] == SND);
    check("src", c, 32'(src), 32'(owner[c]));
    check("odd_slot", c, 32'(odd), 32'((pos / SL) % 2));
    check("slot_start", c, 32'(ss), 32'(resb && ph == 0));
    check("data_latch", c, 32'(dl), 32'(ph == LP && data_src));
    check("vid_ack", c, 32'(va), 32'(ph == SL - 1 && owner[c] == VID));
    check("snd_ack", c, 32'(sa), 32'(ph == SL - 1 && owner[c] == SND));
    check("ref_ack", c, 32'(ra), 32'(ph == SL - 1 && owner[c] == REF));
    check("dma_grant", c, 32'(dg), 32'(granted));
    check("ref_late", c, 32'(rl), 32'(late[c]));
  endtask

  task automatic check_all();
    check_cfg(0, bus_a.src, bus_a.odd_slot, bus_a.slot_start, bus_a.data_latch,
              bus_a.vid_ack, bus_a.snd_ack, bus_a.ref_ack, bus_a.dma_grant, bus_a.ref_late);
    check_cfg(1, bus_b.src, bus_b.odd_slot, bus_b.slot_start, bus_b.data_latch,
              bus_b.vid_ack, bus_b.snd_ack, bus_b.ref_ack, bus_b.dma_grant, bus_b.ref_late);
  endtask

  // Slot-level model advanced once per clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit boundary, next_odd, g_new, r_new, wrap, ref_won;
    int pick;
    if (!resb) begin
      pos = 0;
      granted = 1'b0;
      rel = 1'b0;
      for (int c = 0; c < 2; c++) begin
        owner[c] = IDLE;
        tmr[c] = 0;
        slip[c] = 0;
        pend[c] = 1'b0;
        late[c] = 1'b0;
      end
      return;
    end
    boundary = (pos % SL) == SL - 1;
    next_odd = ((pos / SL) + 1) % 2 == 1;
    g_new = granted;
    r_new = rel;
    if (boundary && rel) begin
      g_new = 1'b0;
      r_new = 1'b0;
    end else if (boundary && !granted && next_odd && dma_req && !cpu_as) begin
      g_new = 1'b1;
    end
    if (granted && !rel && !dma_req) r_new = 1'b1;
    granted = g_new;
    rel = r_new;
    if (boundary) begin
      for (int c = 0; c < 2; c++) begin
        if (next_odd) begin
          owner[c] = granted ? DMA : CPU;
        end else begin
          if (pend[c] && slip[c] >= slip_lim[c]) pick = REF;
          else if (viden && vid_req) pick = VID;
          else if (snd_en && snd_req) pick = SND;
          else if (pend[c]) pick = REF;
          else pick = IDLE;
          owner[c] = pick;
          ref_won = (pick == REF);
          tmr[c] = tmr[c] + 1;
          wrap = (tmr[c] == RI);
          if (wrap) tmr[c] = 0;
          if (wrap && pend[c] && !ref_won) late[c] = 1'b1;
          if (ref_won) slip[c] = 0;
          else if (pend[c] && slip[c] < 255) slip[c] = slip[c] + 1;
          pend[c] = wrap || (pend[c] && !ref_won);
        end
      end
    end
    pos++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk32);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    bit found;
    // Reset, then idle slots
    resb = 1'b0;
    step(3);
    resb = 1'b1;
    step(4 * SL);

    // Video and sound both requesting continuously
    viden = 1'b1; vid_req = 1'b1; snd_en = 1'b1; snd_req = 1'b1;
    step(20 * SL);

    // Video window closed, sound only
    viden = 1'b0;
    step(4 * SL);
    snd_req = 1'b0;

    // DMA request held off by an active CPU cycle
    dma_req = 1'b1; cpu_as = 1'b1;
    step(3 * SL);
    cpu_as = 1'b0;
    step(4 * SL);
    step(3);
    dma_req = 1'b0;
    step(3 * SL);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      viden = 1'($urandom);
      vid_req = 1'($urandom);
      snd_en = 1'($urandom);
      snd_req = 1'($urandom);
      cpu_as = 1'($urandom);
      dma_req = 1'($urandom);
      step($urandom_range(1, 12));
    end

    // Reset in the middle of a VID slot while DMA holds the grant
    viden = 1'b1; vid_req = 1'b1; snd_req = 1'b0; dma_req = 1'b1; cpu_as = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (owner[0] == VID && (pos % SL) == 3 && granted) found = 1'b1;
      else step(1);
    end
    check("reach_vid_phase3", 0, 32'(found), 32'd1);
    resb = 1'b0;
    step(1);
    resb = 1'b1;
    step(2 * SL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
